// File: rtl/kamikaze_imem_responder_pkg.sv
// Shared types for the instruction-memory responder: FSM state encoding,
// half-word select constants and wait-counter sizing.
package kamikaze_imem_responder_pkg;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RD_LO = 3'd1;
  localparam logic [2:0] S_RD_HI = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_PF_LO = 3'd4;
  localparam logic [2:0] S_PF_HI = 3'd5;

  typedef enum logic [2:0] {
    IDLE  = S_IDLE,
    RD_LO = S_RD_LO,
    RD_HI = S_RD_HI,
    DONE  = S_DONE,
    PF_LO = S_PF_LO,
    PF_HI = S_PF_HI
  } state_t;

  localparam logic LO = 1'b0;
  localparam logic HI = 1'b1;

  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/kamikaze_wait_counter.sv
// Loadable down-counter with a zero flag; holds at zero rather than wrapping.
module kamikaze_wait_counter #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             dec,
  input  logic [WIDTH-1:0] load_val,
  output logic             zero
);

  logic [WIDTH-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/kamikaze_imem_responder.sv
// Fetch-side responder: reads a 32-bit instruction as two 16-bit halves, WAIT_STATES extra cycles each.
// Defining KMKZ_IMEM_PREFETCH_EN adds a one-word speculative prefetch of the next sequential word.
module kamikaze_imem_responder
  import kamikaze_imem_responder_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       addr_i,
  input  logic              request_i,
  input  logic              flush_i,
  output logic [31:0]       ir_o,
  output logic              ready_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_rd_o,
  input  logic [15:0]       mem_data_i
);

  localparam int WORD_W = ADDR_W - 1;
  localparam int CNT_W  = cnt_width(WAIT_STATES);

  state_t            state, state_nxt;
  logic [WORD_W-1:0] word;
  logic [WORD_W-1:0] req_word;
  logic [15:0]       lo_half;
  logic [31:0]       ir;
  logic              reading, take_req, cnt_load, cnt_dec, cnt_zero;
  logic              unused_addr;

  assign req_word    = addr_i[ADDR_W:2];
  assign unused_addr = ^{addr_i[31:ADDR_W+1], addr_i[1:0]};
  assign reading     = state inside {RD_LO, RD_HI, PF_LO, PF_HI};

`ifdef KMKZ_IMEM_PREFETCH_EN
  logic [31:0] pf_buf;
  logic        pf_valid, pf_pend, tag_match, in_pf;

  // During and after a prefetch, word holds the tag of the speculated word.
  assign tag_match = (req_word == word);
  assign in_pf     = state inside {PF_LO, PF_HI};
`endif

  always_comb begin
    state_nxt = state;
    take_req  = 1'b0;
    case (state)
      IDLE: begin
        if (request_i) begin
`ifdef KMKZ_IMEM_PREFETCH_EN
          if (pf_valid && tag_match) begin
            state_nxt = DONE;
          end else begin
            state_nxt = RD_LO;
            take_req  = 1'b1;
          end
`else
          state_nxt = RD_LO;
          take_req  = 1'b1;
`endif
        end
      end
      RD_LO: if (cnt_zero) state_nxt = RD_HI;
      RD_HI: if (cnt_zero) state_nxt = DONE;
`ifdef KMKZ_IMEM_PREFETCH_EN
      DONE: state_nxt = PF_LO;
      PF_LO, PF_HI: begin
        if (request_i && !tag_match) begin
          state_nxt = RD_LO;
          take_req  = 1'b1;
        end else if (cnt_zero) begin
          if (state == PF_LO)               state_nxt = PF_HI;
          else if (pf_pend || request_i)    state_nxt = DONE;
          else                              state_nxt = IDLE;
        end
      end
`else
      DONE: state_nxt = IDLE;
`endif
      default: state_nxt = IDLE;
    endcase
    if (flush_i) begin
      state_nxt = IDLE;
      take_req  = 1'b0;
    end
  end

  // The counter reloads on every transition so each phase starts at WAIT_STATES.
  assign cnt_dec  = reading && (state_nxt == state);
  assign cnt_load = !cnt_dec;

  kamikaze_wait_counter #(.WIDTH(CNT_W)) u_wait_counter (
    .clk      (clk_i),
    .rst_n    (rst_i),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (CNT_W'(WAIT_STATES)),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state   <= IDLE;
      word    <= '0;
      lo_half <= '0;
      ir      <= '0;
    end else begin
      state <= state_nxt;
      if (take_req) word <= req_word;
      if ((state == RD_LO || state == PF_LO) && cnt_zero) lo_half <= mem_data_i;
      if (state_nxt == DONE) begin
`ifdef KMKZ_IMEM_PREFETCH_EN
        ir <= (state == IDLE) ? pf_buf : {mem_data_i, lo_half};
`else
        ir <= {mem_data_i, lo_half};
`endif
      end
`ifdef KMKZ_IMEM_PREFETCH_EN
      if (state == DONE && !flush_i) word <= word + 1'b1;
`endif
    end
  end

`ifdef KMKZ_IMEM_PREFETCH_EN
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      pf_buf   <= '0;
      pf_valid <= 1'b0;
      pf_pend  <= 1'b0;
    end else begin
      pf_pend <= in_pf && (state_nxt inside {PF_LO, PF_HI}) && (pf_pend || (request_i && tag_match));
      if (state == PF_HI && cnt_zero && state_nxt == IDLE && !flush_i) begin
        pf_buf   <= {mem_data_i, lo_half};
        pf_valid <= 1'b1;
      end else if (take_req || flush_i || state == DONE) begin
        pf_valid <= 1'b0;
      end
    end
  end
`endif

  assign ir_o       = ir;
  assign ready_o    = (state == DONE);
  assign mem_rd_o   = reading;
  assign mem_addr_o = {word, (state == RD_HI || state == PF_HI) ? HI : LO};

endmodule
